axi_rr_arbiter: RTL and testbench

- Parametrised N-master to 1-slave AXI4 arbiter. Successor to the fixed two-master (IFU/LSU) arbiter that sits in front of the crossbar.
- Read and write paths are arbitrated independently, each with its own round-robin grant. Grant is held across full bursts (AR to last R beat; AW to B). Responses are routed back to the granted master.
- Adds burst-length checking and busy status outputs, so additional masters (DMA, debug) can be added without restructuring.

---
 rtl/axi_rr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// N-master to single-slave AXI4 arbiter. Read and write paths each run their own
// round-robin grant, held for a whole burst, with responses steered back to the owner.
module axi_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    localparam int STRB_W   = DATA_W / 8,
    localparam int GW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    // master-side read address
    input  logic [N_MASTERS-1:0]          i_m_arvalid,
    output logic [N_MASTERS-1:0]          o_m_arready,
    input  logic [N_MASTERS*ADDR_W-1:0]   i_m_araddr,
    input  logic [N_MASTERS*ID_W-1:0]     i_m_arid,
    input  logic [N_MASTERS*8-1:0]        i_m_arlen,
    input  logic [N_MASTERS*3-1:0]        i_m_arsize,
    input  logic [N_MASTERS*2-1:0]        i_m_arburst,
    // master-side read data
    output logic [N_MASTERS-1:0]          o_m_rvalid,
    input  logic [N_MASTERS-1:0]          i_m_rready,
    output logic [DATA_W-1:0]             o_m_rdata,
    output logic [1:0]                    o_m_rresp,
    output logic                          o_m_rlast,
    output logic [ID_W-1:0]               o_m_rid,
    // master-side write address
    input  logic [N_MASTERS-1:0]          i_m_awvalid,
    output logic [N_MASTERS-1:0]          o_m_awready,
    input  logic [N_MASTERS*ADDR_W-1:0]   i_m_awaddr,
    input  logic [N_MASTERS*ID_W-1:0]     i_m_awid,
    input  logic [N_MASTERS*8-1:0]        i_m_awlen,
    input  logic [N_MASTERS*3-1:0]        i_m_awsize,
    input  logic [N_MASTERS*2-1:0]        i_m_awburst,
    // master-side write data
    input  logic [N_MASTERS-1:0]          i_m_wvalid,
    output logic [N_MASTERS-1:0]          o_m_wready,
    input  logic [N_MASTERS*DATA_W-1:0]   i_m_wdata,
    input  logic [N_MASTERS*STRB_W-1:0]   i_m_wstrb,
    input  logic [N_MASTERS-1:0]          i_m_wlast,
    // master-side write response
    output logic [N_MASTERS-1:0]          o_m_bvalid,
    input  logic [N_MASTERS-1:0]          i_m_bready,
    output logic [1:0]                    o_m_bresp,
    output logic [ID_W-1:0]               o_m_bid,
    // slave-side bundle
    output logic                          o_s_arvalid,
    input  logic                          i_s_arready,
    output logic [ADDR_W-1:0]             o_s_araddr,
    output logic [ID_W-1:0]               o_s_arid,
    output logic [7:0]                    o_s_arlen,
    output logic [2:0]                    o_s_arsize,
    output logic [1:0]                    o_s_arburst,
    input  logic                          i_s_rvalid,
    output logic                          o_s_rready,
    input  logic [DATA_W-1:0]             i_s_rdata,
    input  logic [1:0]                    i_s_rresp,
    input  logic                          i_s_rlast,
    input  logic [ID_W-1:0]               i_s_rid,
    output logic                          o_s_awvalid,
    input  logic                          i_s_awready,
    output logic [ADDR_W-1:0]             o_s_awaddr,
    output logic [ID_W-1:0]               o_s_awid,
    output logic [7:0]                    o_s_awlen,
    output logic [2:0]                    o_s_awsize,
    output logic [1:0]                    o_s_awburst,
    output logic                          o_s_wvalid,
    input  logic                          i_s_wready,
    output logic [DATA_W-1:0]             o_s_wdata,
    output logic [STRB_W-1:0]             o_s_wstrb,
    output logic                          o_s_wlast,
    input  logic                          i_s_bvalid,
    output logic                          o_s_bready,
    input  logic [1:0]                    i_s_bresp,
    input  logic [ID_W-1:0]               i_s_bid,
    // status
    output logic                          o_rd_busy,
    output logic                          o_wr_busy,
    output logic [GW-1:0]                 o_rd_grant,
    output logic [GW-1:0]                 o_wr_grant,
    output logic                          o_rlast_err
);

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_ADDR = 2'd1, WR_RESP = 2'd2} wr_state_t;

    // First requester strictly after ptr, wrapping; ptr itself has lowest priority.
    function automatic logic [GW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                              input logic [GW-1:0] ptr);
        logic [GW-1:0] win;
        logic          found;
        int            idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = (int'(ptr) + i) % N_MASTERS;
            if (!found && req[idx]) begin
                win   = GW'(idx);
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    rd_state_t     rd_state_r, rd_state_s;
    logic [GW-1:0] rd_grant_r, rd_grant_s, rd_ptr_r, rd_ptr_s;
    logic [8:0]    rd_cnt_r, rd_cnt_s;
    logic [7:0]    rd_len_r, rd_len_s;
    logic          rlast_err_r, rlast_err_s;
    logic          ar_hs_s, r_hs_s;
    int            rd_idx_s;

    wr_state_t     wr_state_r, wr_state_s;
    logic [GW-1:0] wr_grant_r, wr_grant_s, wr_ptr_r, wr_ptr_s;
    logic          aw_done_r, aw_done_s, w_done_r, w_done_s;
    logic          aw_hs_s, w_hs_s, b_hs_s;
    int            wr_idx_s;

    assign rd_idx_s = int'(rd_grant_r);
    assign wr_idx_s = int'(wr_grant_r);

    assign ar_hs_s = (rd_state_r == RD_ADDR) && o_s_arvalid && i_s_arready;
    assign r_hs_s  = (rd_state_r == RD_DATA) && i_s_rvalid && o_s_rready;
    assign aw_hs_s = (wr_state_r == WR_ADDR) && o_s_awvalid && i_s_awready;
    assign w_hs_s  = (wr_state_r == WR_ADDR) && o_s_wvalid && i_s_wready;
    assign b_hs_s  = (wr_state_r == WR_RESP) && i_s_bvalid && o_s_bready;

    // Read FSM state and burst bookkeeping registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_state_r  <= RD_IDLE;
            rd_grant_r  <= '0;
            rd_ptr_r    <= GW'(N_MASTERS - 1);
            rd_cnt_r    <= 9'd0;
            rd_len_r    <= 8'd0;
            rlast_err_r <= 1'b0;
        end else begin
            rd_state_r  <= rd_state_s;
            rd_grant_r  <= rd_grant_s;
            rd_ptr_r    <= rd_ptr_s;
            rd_cnt_r    <= rd_cnt_s;
            rd_len_r    <= rd_len_s;
            rlast_err_r <= rlast_err_s;
        end
    end

    // Read FSM next state, grant selection and beat-count checking.
    always_comb begin
        rd_state_s  = rd_state_r;
        rd_grant_s  = rd_grant_r;
        rd_ptr_s    = rd_ptr_r;
        rd_cnt_s    = rd_cnt_r;
        rd_len_s    = rd_len_r;
        rlast_err_s = rlast_err_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (|i_m_arvalid) begin
                    rd_grant_s = rr_pick(i_m_arvalid, rd_ptr_r);
                    rd_ptr_s   = rd_grant_s;
                    rd_state_s = RD_ADDR;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_ADDR: begin
                if (ar_hs_s) begin
                    rd_cnt_s   = 9'd0;
                    rd_len_s   = o_s_arlen;
                    rd_state_s = RD_DATA;
                end else begin
                    rd_state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (r_hs_s) begin
                    rd_cnt_s = rd_cnt_r + 9'd1;
                    if (i_s_rlast) begin
                        rd_state_s = RD_IDLE;
                        if (rd_cnt_r != {1'b0, rd_len_r}) begin
                            rlast_err_s = 1'b1;
                        end else begin
                            rlast_err_s = rlast_err_r;
                        end
                    end else if (rd_cnt_r == {1'b0, rd_len_r}) begin
                        // Final beat by count without rlast: flag it, keep waiting.
                        rlast_err_s = 1'b1;
                    end else begin
                        rlast_err_s = rlast_err_r;
                    end
                end else begin
                    rd_state_s = RD_DATA;
                end
            end
            default: rd_state_s = RD_IDLE;
        endcase
    end

    // Read channel steering between the granted master and the slave.
    always_comb begin
        o_m_arready = '0;
        o_m_rvalid  = '0;
        o_s_arvalid = 1'b0;
        o_s_rready  = 1'b0;
        o_s_araddr  = i_m_araddr[rd_idx_s*ADDR_W +: ADDR_W];
        o_s_arid    = i_m_arid[rd_idx_s*ID_W +: ID_W];
        o_s_arlen   = i_m_arlen[rd_idx_s*8 +: 8];
        o_s_arsize  = i_m_arsize[rd_idx_s*3 +: 3];
        o_s_arburst = i_m_arburst[rd_idx_s*2 +: 2];
        case (rd_state_r)
            RD_ADDR: begin
                o_s_arvalid             = i_m_arvalid[rd_grant_r];
                o_m_arready[rd_grant_r] = i_s_arready;
            end
            RD_DATA: begin
                o_m_rvalid[rd_grant_r] = i_s_rvalid;
                o_s_rready             = i_m_rready[rd_grant_r];
            end
            default: o_s_arvalid = 1'b0;
        endcase
    end

    // Write FSM state and AW/W completion flags.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_state_r <= WR_IDLE;
            wr_grant_r <= '0;
            wr_ptr_r   <= GW'(N_MASTERS - 1);
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
        end else begin
            wr_state_r <= wr_state_s;
            wr_grant_r <= wr_grant_s;
            wr_ptr_r   <= wr_ptr_s;
            aw_done_r  <= aw_done_s;
            w_done_r   <= w_done_s;
        end
    end

    // Write FSM next state; AW and W of the owner complete in either order.
    always_comb begin
        wr_state_s = wr_state_r;
        wr_grant_s = wr_grant_r;
        wr_ptr_s   = wr_ptr_r;
        aw_done_s  = aw_done_r;
        w_done_s   = w_done_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (|i_m_awvalid) begin
                    wr_grant_s = rr_pick(i_m_awvalid, wr_ptr_r);
                    wr_ptr_s   = wr_grant_s;
                    wr_state_s = WR_ADDR;
                end else begin
                    wr_state_s = WR_IDLE;
                end
            end
            WR_ADDR: begin
                aw_done_s = aw_done_r | aw_hs_s;
                w_done_s  = w_done_r | (w_hs_s & o_s_wlast);
                if (aw_done_s && w_done_s) begin
                    wr_state_s = WR_RESP;
                end else begin
                    wr_state_s = WR_ADDR;
                end
            end
            WR_RESP: begin
                if (b_hs_s) begin
                    wr_state_s = WR_IDLE;
                    aw_done_s  = 1'b0;
                    w_done_s   = 1'b0;
                end else begin
                    wr_state_s = WR_RESP;
                end
            end
            default: wr_state_s = WR_IDLE;
        endcase
    end

    // Write channel steering; a finished AW or W leg is masked off.
    always_comb begin
        o_m_awready = '0;
        o_m_wready  = '0;
        o_m_bvalid  = '0;
        o_s_awvalid = 1'b0;
        o_s_wvalid  = 1'b0;
        o_s_bready  = 1'b0;
        o_s_awaddr  = i_m_awaddr[wr_idx_s*ADDR_W +: ADDR_W];
        o_s_awid    = i_m_awid[wr_idx_s*ID_W +: ID_W];
        o_s_awlen   = i_m_awlen[wr_idx_s*8 +: 8];
        o_s_awsize  = i_m_awsize[wr_idx_s*3 +: 3];
        o_s_awburst = i_m_awburst[wr_idx_s*2 +: 2];
        o_s_wdata   = i_m_wdata[wr_idx_s*DATA_W +: DATA_W];
        o_s_wstrb   = i_m_wstrb[wr_idx_s*STRB_W +: STRB_W];
        o_s_wlast   = i_m_wlast[wr_grant_r];
        case (wr_state_r)
            WR_ADDR: begin
                o_s_awvalid             = i_m_awvalid[wr_grant_r] & ~aw_done_r;
                o_m_awready[wr_grant_r] = i_s_awready & ~aw_done_r;
                o_s_wvalid              = i_m_wvalid[wr_grant_r] & ~w_done_r;
                o_m_wready[wr_grant_r]  = i_s_wready & ~w_done_r;
            end
            WR_RESP: begin
                o_m_bvalid[wr_grant_r] = i_s_bvalid;
                o_s_bready             = i_m_bready[wr_grant_r];
            end
            default: o_s_awvalid = 1'b0;
        endcase
    end

    assign o_m_rdata   = i_s_rdata;
    assign o_m_rresp   = i_s_rresp;
    assign o_m_rlast   = i_s_rlast;
    assign o_m_rid     = i_s_rid;
    assign o_m_bresp   = i_s_bresp;
    assign o_m_bid     = i_s_bid;

    assign o_rd_busy   = (rd_state_r != RD_IDLE);
    assign o_wr_busy   = (wr_state_r != WR_IDLE);
    assign o_rd_grant  = rd_grant_r;
    assign o_wr_grant  = wr_grant_r;
    assign o_rlast_err = rlast_err_r;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: a 2-master instance for most scenarios and
// a 3-master instance for round-robin fairness.
module tb_axi_rr_arbiter;

    logic clk, rst_n;
    int checks, errors;

    // 2-master instance
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic [1:0]  m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [63:0] m_araddr, m_awaddr, m_wdata;
    logic [7:0]  m_arid, m_awid, m_wstrb;
    logic [15:0] m_arlen, m_awlen;
    logic [5:0]  m_arsize, m_awsize;
    logic [3:0]  m_arburst, m_awburst;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;
    logic        m_rlast;
    logic [3:0]  m_rid, m_bid;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [3:0]  s_arid, s_rid, s_awid, s_wstrb, s_bid;
    logic [7:0]  s_arlen, s_awlen;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic        rd_busy, wr_busy, rlast_err;
    logic [0:0]  rd_grant, wr_grant;

    // 3-master instance (read path exercised only)
    logic [2:0]  b_arvalid, b_arready, b_rvalid, b_rready, b_awready, b_wready, b_bvalid;
    logic [31:0] b_rdata, b_s_araddr, b_s_awaddr, b_s_wdata;
    logic [1:0]  b_rresp, b_bresp, b_s_arburst, b_s_awburst;
    logic        b_rlast, b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready, b_s_rlast;
    logic [3:0]  b_rid, b_bid, b_s_arid, b_s_awid, b_s_wstrb;
    logic [7:0]  b_s_arlen, b_s_awlen;
    logic [2:0]  b_s_arsize, b_s_awsize;
    logic        b_s_awvalid, b_s_wvalid, b_s_wlast, b_s_bready;
    logic        b_rd_busy, b_wr_busy, b_rlast_err;
    logic [1:0]  b_rd_grant, b_wr_grant;

    axi_rr_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_m_arvalid(m_arvalid), .o_m_arready(m_arready), .i_m_araddr(m_araddr),
        .i_m_arid(m_arid), .i_m_arlen(m_arlen), .i_m_arsize(m_arsize), .i_m_arburst(m_arburst),
        .o_m_rvalid(m_rvalid), .i_m_rready(m_rready), .o_m_rdata(m_rdata), .o_m_rresp(m_rresp),
        .o_m_rlast(m_rlast), .o_m_rid(m_rid),
        .i_m_awvalid(m_awvalid), .o_m_awready(m_awready), .i_m_awaddr(m_awaddr),
        .i_m_awid(m_awid), .i_m_awlen(m_awlen), .i_m_awsize(m_awsize), .i_m_awburst(m_awburst),
        .i_m_wvalid(m_wvalid), .o_m_wready(m_wready), .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb),
        .i_m_wlast(m_wlast), .o_m_bvalid(m_bvalid), .i_m_bready(m_bready),
        .o_m_bresp(m_bresp), .o_m_bid(m_bid),
        .o_s_arvalid(s_arvalid), .i_s_arready(s_arready), .o_s_araddr(s_araddr), .o_s_arid(s_arid),
        .o_s_arlen(s_arlen), .o_s_arsize(s_arsize), .o_s_arburst(s_arburst),
        .i_s_rvalid(s_rvalid), .o_s_rready(s_rready), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
        .i_s_rlast(s_rlast), .i_s_rid(s_rid),
        .o_s_awvalid(s_awvalid), .i_s_awready(s_awready), .o_s_awaddr(s_awaddr), .o_s_awid(s_awid),
        .o_s_awlen(s_awlen), .o_s_awsize(s_awsize), .o_s_awburst(s_awburst),
        .o_s_wvalid(s_wvalid), .i_s_wready(s_wready), .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb),
        .o_s_wlast(s_wlast), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready), .i_s_bresp(s_bresp),
        .i_s_bid(s_bid),
        .o_rd_busy(rd_busy), .o_wr_busy(wr_busy), .o_rd_grant(rd_grant), .o_wr_grant(wr_grant),
        .o_rlast_err(rlast_err)
    );

    axi_rr_arbiter #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .ID_W(4)) dut3 (
        .i_clock(clk), .i_reset(rst_n),
        .i_m_arvalid(b_arvalid), .o_m_arready(b_arready), .i_m_araddr(96'h0),
        .i_m_arid(12'h0), .i_m_arlen(24'h0), .i_m_arsize(9'h0), .i_m_arburst(6'h0),
        .o_m_rvalid(b_rvalid), .i_m_rready(b_rready), .o_m_rdata(b_rdata), .o_m_rresp(b_rresp),
        .o_m_rlast(b_rlast), .o_m_rid(b_rid),
        .i_m_awvalid(3'b000), .o_m_awready(b_awready), .i_m_awaddr(96'h0),
        .i_m_awid(12'h0), .i_m_awlen(24'h0), .i_m_awsize(9'h0), .i_m_awburst(6'h0),
        .i_m_wvalid(3'b000), .o_m_wready(b_wready), .i_m_wdata(96'h0), .i_m_wstrb(12'h0),
        .i_m_wlast(3'b000), .o_m_bvalid(b_bvalid), .i_m_bready(3'b000),
        .o_m_bresp(b_bresp), .o_m_bid(b_bid),
        .o_s_arvalid(b_s_arvalid), .i_s_arready(b_s_arready), .o_s_araddr(b_s_araddr),
        .o_s_arid(b_s_arid), .o_s_arlen(b_s_arlen), .o_s_arsize(b_s_arsize), .o_s_arburst(b_s_arburst),
        .i_s_rvalid(b_s_rvalid), .o_s_rready(b_s_rready), .i_s_rdata(32'h0), .i_s_rresp(2'b00),
        .i_s_rlast(b_s_rlast), .i_s_rid(4'h0),
        .o_s_awvalid(b_s_awvalid), .i_s_awready(1'b0), .o_s_awaddr(b_s_awaddr), .o_s_awid(b_s_awid),
        .o_s_awlen(b_s_awlen), .o_s_awsize(b_s_awsize), .o_s_awburst(b_s_awburst),
        .o_s_wvalid(b_s_wvalid), .i_s_wready(1'b0), .o_s_wdata(b_s_wdata), .o_s_wstrb(b_s_wstrb),
        .o_s_wlast(b_s_wlast), .i_s_bvalid(1'b0), .o_s_bready(b_s_bready), .i_s_bresp(2'b00),
        .i_s_bid(4'h0),
        .o_rd_busy(b_rd_busy), .o_wr_busy(b_wr_busy), .o_rd_grant(b_rd_grant),
        .o_wr_grant(b_wr_grant), .o_rlast_err(b_rlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  arv;
        logic        s_arrdy;
        logic        s_rv;
        logic        s_rl;
        logic [1:0]  rrdy;
        logic        e_sarv;
        logic [1:0]  e_arrdy;
        logic [1:0]  e_rv;
        logic        e_srrdy;
        logic        e_grant;
        logic        e_busy;
        logic [31:0] e_addr;
    } rd_vec_t;

    rd_vec_t tbl [12];

    initial begin
        int seen;
        int exp_seq [6];
        checks = 0;
        errors = 0;

        // N=2 contention: m0 (arlen=3, 4 beats with one stall) then m1 (arlen=0).
        tbl[0]  = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h1000};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 32'h1000};
        tbl[2]  = '{2'b10, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 32'h1000};
        tbl[3]  = '{2'b10, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 32'h1000};
        tbl[4]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h1000};
        tbl[5]  = '{2'b10, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 32'h1000};
        tbl[6]  = '{2'b10, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 32'h1000};
        tbl[7]  = '{2'b10, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h1000};
        tbl[8]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 32'h2000};
        tbl[9]  = '{2'b10, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 32'h2000};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 32'h2000};
        tbl[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 32'h2000};

        rst_n = 1'b0;
        m_arvalid = 2'b11; m_awvalid = 2'b11; m_wvalid = 2'b11; m_wlast = 2'b00;
        m_araddr = {32'h2000, 32'h1000}; m_arid = {4'h2, 4'h1}; m_arlen = {8'd0, 8'd3};
        m_arsize = 6'b010_010; m_arburst = 4'b01_01;
        m_awaddr = 64'h0; m_awid = 8'h0; m_awlen = 16'h0; m_awsize = 6'b010_010; m_awburst = 4'b01_01;
        m_wdata = 64'h0; m_wstrb = 8'hFF; m_rready = 2'b11; m_bready = 2'b11;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00; s_rid = 4'h0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'h0;
        b_arvalid = 3'b000; b_s_arready = 1'b0; b_s_rvalid = 1'b0; b_s_rlast = 1'b0; b_rready = 3'b111;

        // Reset held with everybody requesting.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_arvalid", s_arvalid, 1'b0);
        chk("rst_m_arready", m_arready, 2'b00);
        chk("rst_m_rvalid", m_rvalid, 2'b00);
        chk("rst_s_awvalid", s_awvalid, 1'b0);
        chk("rst_s_wvalid", s_wvalid, 1'b0);
        chk("rst_m_bvalid", m_bvalid, 2'b00);
        chk("rst_busy", {rd_busy, wr_busy}, 2'b00);
        chk("rst_grants", {rd_grant, wr_grant}, 2'b00);
        chk("rst_rlast_err", rlast_err, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            m_arvalid = tbl[i].arv;
            s_arready = tbl[i].s_arrdy;
            s_rvalid  = tbl[i].s_rv;
            s_rlast   = tbl[i].s_rl;
            m_rready  = tbl[i].rrdy;
            #1;
            chk($sformatf("v%0d_s_arvalid", i), s_arvalid, tbl[i].e_sarv);
            chk($sformatf("v%0d_m_arready", i), m_arready, tbl[i].e_arrdy);
            chk($sformatf("v%0d_m_rvalid", i), m_rvalid, tbl[i].e_rv);
            chk($sformatf("v%0d_s_rready", i), s_rready, tbl[i].e_srrdy);
            chk($sformatf("v%0d_rd_grant", i), rd_grant, tbl[i].e_grant);
            chk($sformatf("v%0d_rd_busy", i), rd_busy, tbl[i].e_busy);
            chk($sformatf("v%0d_s_araddr", i), s_araddr, tbl[i].e_addr);
            @(negedge clk);
        end
        chk("contention_rlast_err", rlast_err, 1'b0);

        // N=3 fairness: every master requests continuously with single-beat bursts.
        exp_seq = '{0, 1, 2, 0, 1, 2};
        seen = 0;
        b_arvalid = 3'b111; b_s_arready = 1'b1; b_s_rvalid = 1'b1; b_s_rlast = 1'b1;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            #1;
            if (b_s_arvalid) begin
                chk($sformatf("fair_grant%0d", seen), b_rd_grant, exp_seq[seen]);
                seen++;
            end
            @(negedge clk);
        end
        chk("fair_bursts_seen", seen, 6);
        b_arvalid = 3'b000;
        repeat (3) @(negedge clk);
        chk("fair_rlast_err", b_rlast_err, 1'b0);

        // Concurrency: m1 reads 8 beats while m0 writes 2 beats, W ahead of AW.
        m_arvalid = 2'b10; m_arlen = {8'd7, 8'd3}; m_arid = {4'h5, 4'h1};
        s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b10;
        m_awvalid = 2'b01; m_awid = {4'h3, 4'hA}; m_awlen = {8'd0, 8'd1}; m_awaddr = {32'h0, 32'h4000};
        m_wvalid = 2'b01; m_wlast = 2'b00; m_wdata = {32'h0, 32'hCAFE0001};
        s_awready = 1'b0; s_wready = 1'b1; s_bvalid = 1'b0; m_bready = 2'b11;
        #1;
        chk("cc0_busy", {rd_busy, wr_busy}, 2'b00);
        @(negedge clk);
        #1;
        chk("cc1_s_arvalid", s_arvalid, 1'b1);
        chk("cc1_m_arready", m_arready, 2'b10);
        chk("cc1_s_arid", s_arid, 4'h5);
        chk("cc1_s_awvalid", s_awvalid, 1'b1);
        chk("cc1_m_awready", m_awready, 2'b00);
        chk("cc1_s_wvalid", s_wvalid, 1'b1);
        chk("cc1_m_wready", m_wready, 2'b01);
        chk("cc1_s_wdata", s_wdata, 32'hCAFE0001);
        @(negedge clk);
        m_arvalid = 2'b00; m_wdata = {32'h0, 32'hCAFE0002}; m_wlast = 2'b01;
        #1;
        chk("cc2_s_wlast", {s_wvalid, s_wlast}, 2'b11);
        chk("cc2_s_awvalid", s_awvalid, 1'b1);
        chk("cc2_busy", {rd_busy, wr_busy}, 2'b11);
        chk("cc2_s_rready", s_rready, 1'b1);
        chk("cc2_m_rvalid", m_rvalid, 2'b00);
        @(negedge clk);
        s_awready = 1'b1;
        #1;
        chk("cc3_s_wvalid_masked", s_wvalid, 1'b0);
        chk("cc3_m_wready_masked", m_wready, 2'b00);
        chk("cc3_m_awready", m_awready, 2'b01);
        chk("cc3_s_awid", s_awid, 4'hA);
        chk("cc3_s_awlen", s_awlen, 8'd1);
        @(negedge clk);
        m_awvalid = 2'b00; m_wvalid = 2'b00; m_wlast = 2'b00; s_awready = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b10; s_bid = 4'hA;
        #1;
        chk("cc4_m_bvalid", m_bvalid, 2'b01);
        chk("cc4_s_bready", s_bready, 1'b1);
        chk("cc4_m_bid", m_bid, 4'hA);
        chk("cc4_m_bresp", m_bresp, 2'b10);
        chk("cc4_wr_grant", wr_grant, 1'b0);
        chk("cc4_busy", {rd_busy, wr_busy}, 2'b11);
        @(negedge clk);
        #1;
        chk("cc5_wr_busy", wr_busy, 1'b0);
        chk("cc5_m_bvalid_idle", m_bvalid, 2'b00);
        chk("cc5_s_bready_idle", s_bready, 1'b0);
        s_bvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            s_rvalid = 1'b1; s_rlast = (i == 7); s_rid = 4'h5; s_rdata = 32'(i);
            #1;
            chk($sformatf("cc_beat%0d_m_rvalid", i), m_rvalid, 2'b10);
            chk($sformatf("cc_beat%0d_m_rid", i), m_rid, 4'h5);
            @(negedge clk);
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        chk("cc_end_rd_busy", rd_busy, 1'b0);
        chk("cc_end_rlast_err", rlast_err, 1'b0);

        // Early rlast: arlen=3 but slave ends on the second beat.
        @(negedge clk);
        m_arvalid = 2'b01; m_arlen = {8'd0, 8'd3}; s_arready = 1'b1; m_rready = 2'b01;
        repeat (2) @(negedge clk);
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b0;
        @(negedge clk);
        s_rlast = 1'b1;
        #1;
        chk("err_beat2_m_rvalid", m_rvalid, 2'b01);
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        chk("err_rd_busy", rd_busy, 1'b0);
        chk("err_rlast_err_set", rlast_err, 1'b1);
        m_arvalid = 2'b01; m_arlen = {8'd0, 8'd0};
        repeat (2) @(negedge clk);
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b1;
        @(negedge clk);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        chk("err_sticky_busy", rd_busy, 1'b0);
        chk("err_rlast_err_sticky", rlast_err, 1'b1);

        // Reset during the second beat of an 8-beat read from m0.
        m_arvalid = 2'b01; m_arlen = {8'd0, 8'd7};
        repeat (2) @(negedge clk);
        m_arvalid = 2'b00; s_rvalid = 1'b1; s_rlast = 1'b0; m_rready = 2'b01;
        @(negedge clk);
        #1;
        chk("mid_pre_m_rvalid", m_rvalid, 2'b01);
        chk("mid_pre_s_rready", s_rready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_s_rready", s_rready, 1'b0);
        chk("mid_m_rvalid", m_rvalid, 2'b00);
        chk("mid_rd_busy", rd_busy, 1'b0);
        chk("mid_rlast_err", rlast_err, 1'b0);
        s_rvalid = 1'b0;
        m_arvalid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", s_arvalid, 1'b0);
        @(negedge clk);
        #1;
        chk("post_rst_grant", rd_grant, 1'b0);
        chk("post_rst_s_arvalid", s_arvalid, 1'b1);
        chk("post_rst_m_arready", m_arready, 2'b01);
        m_arvalid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
